// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and constants for the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam int          c_reg_addr_w = 5;
    // Instruction word injected by IF/ID flush consumers (addi x0, x0, 0)
    localparam logic [31:0] c_nop        = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
`default_nettype none
// ============================================================================
// Module      : load_use_detect
// Description : Combinational load-use comparator (ID sources vs EX load rd).
// Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect #(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    output logic                  load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
    assign w_rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
    // x0 is hardwired zero, so a load targeting it never creates a hazard
    assign load_use  = ex_mem_read && (ex_rd != '0) && (w_rs1_hit || w_rs2_hit);

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : 5-stage pipeline sequencer: memory-wait stall, EX redirect
//               flush and load-use interlock. Optional perf counters are
//               enabled with PIPE_HAZARD_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = c_reg_addr_w,
    parameter int MEM_TIMEOUT = 16
`ifdef PIPE_HAZARD_PERF_EN
   ,parameter int CNT_W       = 32
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_redirect,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_we,
    output logic                  pc_sel_target,
    output logic                  ifid_we,
    output logic                  ifid_flush,
    output logic                  idex_we,
    output logic                  idex_flush,
    output logic                  exmem_we,
    output logic                  memwb_bubble,
    output logic                  mem_timeout
`ifdef PIPE_HAZARD_PERF_EN
   ,output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count,
    output logic [CNT_W-1:0]      timeout_count
`endif
);

    localparam int              c_cw       = $clog2(MEM_TIMEOUT);
    localparam logic [c_cw-1:0] c_wait_max = c_cw'(MEM_TIMEOUT - 1);

    state_t          r_state;
    logic [c_cw-1:0] r_wait_cnt;
    logic            w_load_use;
    logic            w_force;
    logic            w_mem_stall;
    logic            w_timeout;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_use    (w_load_use)
    );

    assign w_force     = (r_state == MEM_WAIT) && (r_wait_cnt == c_wait_max);
    assign w_mem_stall = mem_req && !mem_ready && !w_force;
    // Forced release only pulses when the access is genuinely still pending
    assign w_timeout   = w_force && mem_req && !mem_ready;

    always_comb begin
        pc_we         = 1'b1;
        pc_sel_target = 1'b0;
        ifid_we       = 1'b1;
        ifid_flush    = 1'b0;
        idex_we       = 1'b1;
        idex_flush    = 1'b0;
        exmem_we      = 1'b1;
        memwb_bubble  = 1'b0;
        mem_timeout   = 1'b0;
        if (rst) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            exmem_we     = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            memwb_bubble = 1'b1;
        end else if (w_mem_stall) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            exmem_we     = 1'b0;
            memwb_bubble = 1'b1;
        end else begin
            mem_timeout = w_timeout;
            if (ex_redirect) begin
                pc_sel_target = 1'b1;
                ifid_flush    = 1'b1;
                idex_flush    = 1'b1;
            end else if (w_load_use) begin
                pc_we      = 1'b0;
                ifid_we    = 1'b0;
                idex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_mem_stall) begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= c_cw'(1);
                    end
                end
                MEM_WAIT: begin
                    // Ready, forced release and a dropped request all return to RUN
                    if (w_mem_stall) begin
                        r_wait_cnt <= r_wait_cnt + c_cw'(1);
                    end else begin
                        r_state    <= RUN;
                        r_wait_cnt <= '0;
                    end
                end
                default: begin
                    r_state    <= RUN;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles  <= '0;
            flush_count   <= '0;
            timeout_count <= '0;
        end else begin
            if ((w_mem_stall || w_load_use) && stall_cycles != c_cnt_max)
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (ex_redirect && !w_mem_stall && flush_count != c_cnt_max)
                flush_count <= flush_count + CNT_W'(1);
            if (w_timeout && timeout_count != c_cnt_max)
                timeout_count <= timeout_count + CNT_W'(1);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed self-checking bench for pipe_hazard_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    // {pc_we, pc_sel_target, ifid_we, ifid_flush, idex_we, idex_flush,
    //  exmem_we, memwb_bubble, mem_timeout}
    localparam logic [8:0] c_v_rst   = 9'b000101010;
    localparam logic [8:0] c_v_run   = 9'b101010100;
    localparam logic [8:0] c_v_lu    = 9'b000011100;
    localparam logic [8:0] c_v_redir = 9'b111111100;
    localparam logic [8:0] c_v_stall = 9'b000000010;
    localparam logic [8:0] c_v_to    = 9'b101010101;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect;
    logic       mem_req, mem_ready;
    logic       pc_we, pc_sel_target, ifid_we, ifid_flush, idex_we;
    logic       idex_flush, exmem_we, memwb_bubble, mem_timeout;
    logic [8:0] w_outs;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cycles, flush_count, timeout_count;
`endif

    int n_total = 0;
    int n_pass  = 0;

    pipe_hazard_ctrl #(
        .REG_ADDR_W  (5),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_use_rs1    (id_use_rs1),
        .id_use_rs2    (id_use_rs2),
        .ex_rd         (ex_rd),
        .ex_mem_read   (ex_mem_read),
        .ex_redirect   (ex_redirect),
        .mem_req       (mem_req),
        .mem_ready     (mem_ready),
        .pc_we         (pc_we),
        .pc_sel_target (pc_sel_target),
        .ifid_we       (ifid_we),
        .ifid_flush    (ifid_flush),
        .idex_we       (idex_we),
        .idex_flush    (idex_flush),
        .exmem_we      (exmem_we),
        .memwb_bubble  (memwb_bubble),
        .mem_timeout   (mem_timeout)
`ifdef PIPE_HAZARD_PERF_EN
       ,.stall_cycles  (stall_cycles),
        .flush_count   (flush_count),
        .timeout_count (timeout_count)
`endif
    );

    assign w_outs = {pc_we, pc_sel_target, ifid_we, ifid_flush, idex_we,
                     idex_flush, exmem_we, memwb_bubble, mem_timeout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Inputs are applied at the falling edge; outputs checked 1 ns later
    task automatic step(input string tag, input logic [8:0] exp);
        #1;
        check(tag, 32'(w_outs), 32'(exp));
        @(negedge clk);
    endtask

    task automatic check_state(input string tag, input state_t exp);
        check(tag, 32'(dut.r_state), 32'(exp));
    endtask

    initial begin
        rst = 1'b1;
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_redirect = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
        #1;
        check("reset_outs", 32'(w_outs), 32'(c_v_rst));
        check_state("reset_state", RUN);
        @(negedge clk);
        rst = 1'b0;
        step("idle", c_v_run);

        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        step("load_use_rs1", c_v_lu);
        ex_mem_read = 1'b0;
        step("load_use_clear", c_v_run);
        ex_mem_read = 1'b1; ex_redirect = 1'b1;
        step("redirect_over_lu", c_v_redir);
        ex_mem_read = 1'b0; ex_redirect = 1'b0;
        step("after_redirect", c_v_run);

        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("mem_wait", c_v_stall);
            check_state("mem_wait_state", MEM_WAIT);
        end
        mem_ready = 1'b1;
        step("mem_done", c_v_run);
        check_state("mem_done_state", RUN);

        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("to_stall", c_v_stall);
        step("timeout_release", c_v_to);
        check_state("timeout_state", RUN);
        mem_req = 1'b0;
        step("post_timeout", c_v_run);

        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        step("x0_no_stall", c_v_run);

`ifdef PIPE_HAZARD_PERF_EN
        check("stall_cycles", stall_cycles, 32'd8);
        check("flush_count", flush_count, 32'd1);
        check("timeout_count", timeout_count, 32'd1);
`endif

        ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs1 = 1'b0; id_use_rs2 = 1'b1;
        step("load_use_rs2", c_v_lu);
        id_use_rs2 = 1'b0;
        step("rs2_not_used", c_v_run);
        ex_mem_read = 1'b0;

        mem_req = 1'b1; mem_ready = 1'b1;
        step("single_cycle_mem", c_v_run);
        check_state("single_cycle_state", RUN);

        mem_ready = 1'b0; ex_redirect = 1'b1;
        step("stall_over_redirect", c_v_stall);
        ex_redirect = 1'b0; mem_req = 1'b0;
        step("req_drop", c_v_run);
        check_state("req_drop_state", RUN);

        mem_req = 1'b1;
        step("pre_reset_stall", c_v_stall);
        check_state("pre_reset_state", MEM_WAIT);
        #2 rst = 1'b1;
        #1;
        check("async_reset_outs", 32'(w_outs), 32'(c_v_rst));
        check_state("async_reset_state", RUN);
        @(negedge clk);
        rst = 1'b0; mem_req = 1'b0;
        step("after_reset", c_v_run);
        check_state("after_reset_state", RUN);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
